// File: rtl/fmps_pkg.sv
// Shared definitions for the FMPS readout buffer (writer and readout streamer).
// Contents:
//   CSR_*          bit positions inside the fmpsCSR status word
//   fmps_state_t   writer interval state encoding
//   fmps_pack_csr  assembles the status word from its fields
package fmps_pkg;

  localparam int unsigned CSR_ACTIVE_BIT  = 31;
  localparam int unsigned CSR_VALID_BIT   = 30;
  localparam int unsigned CSR_TIMEOUT_BIT = 29;
  localparam int unsigned CSR_DUP_LSB     = 16;
  localparam int unsigned CSR_DUP_WIDTH   = 8;
  localparam int unsigned CSR_COUNT_WIDTH = 9;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fmps_state_t;

  // Count is passed zero-extended to 9 bits so the field covers INDEX_WIDTH up to 8.
  function automatic logic [31:0] fmps_pack_csr(
    input logic                       active,
    input logic                       valid,
    input logic                       timed_out,
    input logic [CSR_DUP_WIDTH-1:0]   dup,
    input logic [CSR_COUNT_WIDTH-1:0] count
  );
    logic [31:0] csr;
    csr                                          = '0;
    csr[CSR_ACTIVE_BIT]                          = active;
    csr[CSR_VALID_BIT]                           = valid;
    csr[CSR_TIMEOUT_BIT]                         = timed_out;
    csr[CSR_DUP_LSB +: CSR_DUP_WIDTH]            = dup;
    csr[CSR_COUNT_WIDTH-1:0]                     = count;
    return csr;
  endfunction

endpackage

// File: rtl/fmps_interval_timer.sv
// Acquisition-interval down-counter.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   load         loads load_value (takes priority over counting)
//   load_value   interval length in cycles; 0 disables expiry
//   enable       counting enabled (interval open)
//   expired      combinational: counter at 1 while enabled, interval ends on next edge
module fmps_interval_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        enable,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  // A zero count never matches, so a zero load value disables expiry.
  assign expired = enable && (count == 32'd1);

endmodule

// File: rtl/fmps_readout_writer.sv
// Producer side of the FMPS readout buffer: writes the per-index packet stream into
// the readout RAM and maintains the presence bitmap and interval status word.
// Ports:
//   sysClk, sysReset    clock, synchronous active-high reset
//   acqStart            strobe opening (or restarting) an acquisition interval
//   acqTimeout          interval length in cycles, 0 = no timeout
//   fmpsExpectedMask    indices required for completion, latched on acqStart
//   fmpsIndex/Data/Valid inbound packet stream
//   fmpsWriteAddress/Data/Enable  registered RAM write port
//   fmpsBitmapAll       presence bitmap of the current/last interval
//   fmpsCSR             [31] active [30] valid [29] timedOut [23:16] duplicates
//                       [INDEX_WIDTH:0] distinct packets
// Build option: define FMPS_DUPLICATE_COUNT_EN to implement the saturating duplicate
// counter; otherwise fmpsCSR[23:16] reads 0.
module fmps_readout_writer
  import fmps_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 5
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        acqStart,
  input  logic [31:0]                 acqTimeout,
  input  logic [(1<<INDEX_WIDTH)-1:0] fmpsExpectedMask,
  input  logic [INDEX_WIDTH-1:0]      fmpsIndex,
  input  logic [31:0]                 fmpsData,
  input  logic                        fmpsValid,
  output logic [INDEX_WIDTH-1:0]      fmpsWriteAddress,
  output logic [31:0]                 fmpsWriteData,
  output logic                        fmpsWriteEnable,
  output logic [(1<<INDEX_WIDTH)-1:0] fmpsBitmapAll,
  output logic [31:0]                 fmpsCSR
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

  fmps_state_t             state;
  logic [DEPTH-1:0]        mask;
  logic [INDEX_WIDTH:0]    count;
  logic                    active;
  logic                    valid_flag;
  logic                    timed_out;
  logic [CSR_DUP_WIDTH-1:0] dup_count;

  logic                    accept;
  logic                    bit_was_set;
  logic                    complete;
  logic                    expired;
  logic [DEPTH-1:0]        index_bit;

  // A packet alongside acqStart belongs to the new interval, so it is accepted even
  // from idle and sees the bitmap as already cleared.
  assign accept      = fmpsValid && ((state == ST_ACTIVE) || acqStart);
  assign bit_was_set = !acqStart && fmpsBitmapAll[fmpsIndex];
  assign complete    = ((fmpsBitmapAll & mask) == mask);
  assign index_bit   = DEPTH'(1) << fmpsIndex;

  fmps_interval_timer u_timer (
    .clk        (sysClk),
    .reset      (sysReset),
    .load       (acqStart),
    .load_value (acqTimeout),
    .enable     (state == ST_ACTIVE),
    .expired    (expired)
  );

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state            <= ST_IDLE;
      mask             <= '0;
      count            <= '0;
      active           <= 1'b0;
      valid_flag       <= 1'b0;
      timed_out        <= 1'b0;
      fmpsBitmapAll    <= '0;
      fmpsWriteEnable  <= 1'b0;
      fmpsWriteAddress <= '0;
      fmpsWriteData    <= '0;
    end else begin
      fmpsWriteEnable <= accept;
      if (accept) begin
        fmpsWriteAddress <= fmpsIndex;
        fmpsWriteData    <= fmpsData;
      end

      if (acqStart) begin
        state         <= ST_ACTIVE;
        mask          <= fmpsExpectedMask;
        active        <= 1'b1;
        valid_flag    <= 1'b0;
        timed_out     <= 1'b0;
        fmpsBitmapAll <= accept ? index_bit : '0;
        count         <= accept ? (INDEX_WIDTH+1)'(1) : '0;
      end else if (state == ST_ACTIVE) begin
        if (accept) begin
          fmpsBitmapAll <= fmpsBitmapAll | index_bit;
          if (!bit_was_set) begin
            count <= count + (INDEX_WIDTH+1)'(1);
          end
        end
        // Completion is judged on the registered bitmap and wins over expiry.
        if (complete) begin
          state      <= ST_IDLE;
          active     <= 1'b0;
          valid_flag <= 1'b1;
        end else if (expired) begin
          state     <= ST_IDLE;
          active    <= 1'b0;
          timed_out <= 1'b1;
        end
      end
    end
  end

`ifdef FMPS_DUPLICATE_COUNT_EN
  always_ff @(posedge sysClk) begin
    if (sysReset || acqStart) begin
      dup_count <= '0;
    end else if (accept && bit_was_set && (dup_count != '1)) begin
      dup_count <= dup_count + CSR_DUP_WIDTH'(1);
    end
  end
`else
  assign dup_count = '0;
`endif

  assign fmpsCSR = fmps_pack_csr(active, valid_flag, timed_out, dup_count,
                                 CSR_COUNT_WIDTH'(count));

endmodule

// File: tb/tb_fmps_readout_writer.sv
module tb_fmps_readout_writer;

  logic        clk;
  logic        rst;
  logic        acq_start;
  logic [31:0] acq_timeout;
  logic [31:0] exp_mask;
  logic [4:0]  idx;
  logic [31:0] data;
  logic        pkt_valid;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] bitmap;
  logic [31:0] csr;

  logic [31:0] mem [32];
  int          checks;
  int          errors;
  logic [31:0] dup_field;

  fmps_readout_writer #(.INDEX_WIDTH(5)) dut (
    .sysClk           (clk),
    .sysReset         (rst),
    .acqStart         (acq_start),
    .acqTimeout       (acq_timeout),
    .fmpsExpectedMask (exp_mask),
    .fmpsIndex        (idx),
    .fmpsData         (data),
    .fmpsValid        (pkt_valid),
    .fmpsWriteAddress (waddr),
    .fmpsWriteData    (wdata),
    .fmpsWriteEnable  (we),
    .fmpsBitmapAll    (bitmap),
    .fmpsCSR          (csr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side RAM fed by the write port.
  always @(posedge clk) if (we) mem[waddr] <= wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; acq_start = 1'b0; acq_timeout = '0; exp_mask = '0;
    idx = '0; data = '0; pkt_valid = 1'b0;
    tick(); tick();
    checks++;
    if (csr !== 32'h0 || bitmap !== 32'h0 || we !== 1'b0 || waddr !== 5'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: csr=%h bitmap=%h we=%b addr=%h data=%h, required all 0", csr, bitmap, we, waddr, wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_complete();
    exp_mask = 32'hF; acq_timeout = 0; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    checks++;
    if (csr !== 32'h8000_0000) begin
      errors++; $display("FAIL start_csr: got %h want 80000000", csr);
    end
    for (int i = 0; i < 4; i++) begin
      pkt_valid = 1'b1; idx = 5'(i); data = 32'hA0 + 32'(i);
      tick();
      checks++;
      if (we !== 1'b1 || waddr !== 5'(i) || wdata !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL write_%0d: we=%b addr=%h data=%h, want 1/%h/%h", i, we, waddr, wdata, i, 32'hA0 + i);
      end
    end
    pkt_valid = 1'b0;
    checks++;
    if (csr !== 32'h8000_0004 || bitmap !== 32'hF) begin
      errors++; $display("FAIL pre_valid: csr=%h bitmap=%h want 80000004/f", csr, bitmap);
    end
    tick();
    checks++;
    if (csr !== 32'h4000_0004 || bitmap !== 32'hF || we !== 1'b0) begin
      errors++; $display("FAIL complete: csr=%h bitmap=%h we=%b want 40000004/f/0", csr, bitmap, we);
    end
    tick();
    checks++;
    if (mem[0] !== 32'hA0 || mem[1] !== 32'hA1 || mem[2] !== 32'hA2 || mem[3] !== 32'hA3) begin
      errors++; $display("FAIL ram_contents: %h %h %h %h want a0 a1 a2 a3", mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_mask = 32'hF; acq_timeout = 100; acq_start = 1'b1;
    tick();
    acq_start = 1'b0; n = 0;
    pkt_valid = 1'b1; idx = 5'd0; data = 32'h1;
    tick(); n++;
    idx = 5'd1; data = 32'h2;
    tick(); n++;
    pkt_valid = 1'b0;
    while (csr[31] === 1'b1 && n < 200) begin
      tick(); n++;
    end
    checks++;
    if (n !== 100) begin
      errors++; $display("FAIL timeout_cycle: active fell after %0d cycles, want 100", n);
    end
    checks++;
    if (csr !== 32'h2000_0002 || bitmap !== 32'h3) begin
      errors++; $display("FAIL timeout_csr: csr=%h bitmap=%h want 20000002/3", csr, bitmap);
    end
  endtask

  task automatic test_duplicate();
`ifdef FMPS_DUPLICATE_COUNT_EN
    dup_field = 32'h0001_0000;
`else
    dup_field = 32'h0;
`endif
    exp_mask = 32'h3; acq_timeout = 0; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    pkt_valid = 1'b1; idx = 5'd0; data = 32'h11;
    tick();
    data = 32'h22;
    tick();
    idx = 5'd1; data = 32'h33;
    tick();
    pkt_valid = 1'b0;
    checks++;
    if (csr !== (32'h8000_0002 | dup_field)) begin
      errors++; $display("FAIL dup_active: csr=%h want %h", csr, 32'h8000_0002 | dup_field);
    end
    tick();
    checks++;
    if (csr !== (32'h4000_0002 | dup_field)) begin
      errors++; $display("FAIL dup_complete: csr=%h want %h", csr, 32'h4000_0002 | dup_field);
    end
    checks++;
    if (mem[0] !== 32'h22 || mem[1] !== 32'h33) begin
      errors++; $display("FAIL dup_ram: ram0=%h ram1=%h want 22/33", mem[0], mem[1]);
    end
  endtask

  task automatic test_idle_and_same_cycle();
    pkt_valid = 1'b1; idx = 5'd5; data = 32'h99;
    tick();
    checks++;
    if (we !== 1'b0 || bitmap !== 32'h3) begin
      errors++; $display("FAIL idle_drop: we=%b bitmap=%h want 0/3", we, bitmap);
    end
    exp_mask = 32'h60; acq_start = 1'b1; data = 32'h55;
    tick();
    acq_start = 1'b0; pkt_valid = 1'b0;
    checks++;
    if (bitmap !== 32'h20 || csr !== 32'h8000_0001 || we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h55) begin
      errors++;
      $display("FAIL same_cycle: bitmap=%h csr=%h we=%b addr=%h data=%h want 20/80000001/1/5/55", bitmap, csr, we, waddr, wdata);
    end
  endtask

  task automatic test_restart();
    int pulses;
    exp_mask = 32'h7; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1; idx = 5'(i); data = 32'hC0 + 32'(i);
      tick();
    end
    pkt_valid = 1'b0;
    checks++;
    if (csr !== 32'h8000_0003) begin
      errors++; $display("FAIL restart_pre: csr=%h want 80000003", csr);
    end
    exp_mask = 32'hF0; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    checks++;
    if (csr !== 32'h8000_0000 || bitmap !== 32'h0) begin
      errors++; $display("FAIL restart_clear: csr=%h bitmap=%h want 80000000/0", csr, bitmap);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (csr[30] !== 1'b0 || csr[31] !== 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL restart_no_valid: %0d bad cycles, want 0", pulses);
    end
    exp_mask = 32'h0; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    checks++;
    if (csr !== 32'h8000_0000) begin
      errors++; $display("FAIL mask0_start: csr=%h want 80000000", csr);
    end
    tick();
    checks++;
    if (csr !== 32'h4000_0000) begin
      errors++; $display("FAIL mask0_complete: csr=%h want 40000000", csr);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    exp_mask = 32'hF; acq_timeout = 5; acq_start = 1'b1;
    tick();
    acq_start = 1'b0;
    pkt_valid = 1'b1; idx = 5'd2; data = 32'h77;
    tick();
    rst = 1'b1; idx = 5'd3;
    tick();
    checks++;
    if (csr !== 32'h0 || bitmap !== 32'h0 || we !== 1'b0 || waddr !== 5'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: csr=%h bitmap=%h we=%b addr=%h data=%h want all 0", csr, bitmap, we, waddr, wdata);
    end
    rst = 1'b0; idx = 5'd4;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we !== 1'b0 || bitmap !== 32'h0 || csr !== 32'h0) bad++;
    end
    pkt_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL post_reset_drop: %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_complete();
    test_timeout();
    test_duplicate();
    test_idle_and_same_cycle();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmps_readout_writer.md
Name: fmps_readout_writer

Overview:
- Producer side of the FMPS readout buffer.
- Accepts the per-index FMPS packet stream recovered from the cell link and writes each packet into the readout RAM.
- Maintains the presence bitmap and the acquisition-interval status word (active/valid bits) that the downstream readout streamer polls.
- Defines one acquisition interval: start strobe, then packet collection, then completion or timeout.

Parameters:
- INDEX_WIDTH, 5, width of FMPS index; RAM depth and bitmap width = 1<<INDEX_WIDTH (INDEX_WIDTH ≤ 8).

Ports:
- sysClk  in  1  system clock; all logic on rising edge
- sysReset  in  1  synchronous, active-high reset
- acqStart  in  1  single-cycle strobe; opens a new acquisition interval
- acqTimeout  in  32  interval length in sysClk cycles; 0 = no timeout
- fmpsExpectedMask  in  1<<INDEX_WIDTH  indices required for completion; sampled on acqStart
- fmpsIndex  in  INDEX_WIDTH  inbound packet index
- fmpsData  in  32  inbound packet payload
- fmpsValid  in  1  inbound packet strobe, one packet per cycle max
- fmpsWriteAddress  out  INDEX_WIDTH  RAM write address
- fmpsWriteData  out  32  RAM write data
- fmpsWriteEnable  out  1  RAM write strobe
- fmpsBitmapAll  out  1<<INDEX_WIDTH  presence bitmap, bit i = index i written this interval
- fmpsCSR  out  32  status word: [31] active, [30] valid, [29] timedOut, [23:16] duplicate count (optional), [INDEX_WIDTH:0] distinct packets received, others 0

Behaviour:
- Reset:
  - all outputs 0; state ST_IDLE; latched mask 0; timeout counter 0.
  - Reset mid-interval aborts the interval; no completion or timeout event is produced.
- States: ST_IDLE, ST_ACTIVE.
- ST_IDLE:
  - fmpsValid ignored: no write, no bitmap change.
  - acqStart moves to ST_ACTIVE. On that edge:
    - bitmap cleared, count cleared, duplicate count cleared
    - active=1, valid=0, timedOut=0
    - mask latched; counter loaded with acqTimeout.
- acqStart in ST_ACTIVE restarts the interval with identical clearing; the previous interval produces no valid.
- Packet acceptance in ST_ACTIVE, fmpsValid at cycle N:
  - at N+1: fmpsWriteEnable=1, address/data registered copies, bitmap[fmpsIndex]=1.
  - Count increments only if the bit was previously 0.
  - Duplicates are always rewritten (latest data wins).
- Packet and acqStart in the same cycle: the packet belongs to the new interval. The clear takes effect first, then the packet's bit is set.
- Completion:
  - When (bitmap & mask) == mask, evaluated on registered bitmap: next cycle valid=1, active=0, go to ST_IDLE.
  - Latency from the final required packet's fmpsValid to valid rising = 2 cycles.
  - mask == 0: completes 2 cycles after acqStart.
- Timeout:
  - In ST_ACTIVE with acqTimeout != 0, the counter decrements each cycle.
  - At counter reaching 1 without completion: next cycle active=0, timedOut=1, valid=0, go to ST_IDLE.
  - Completion and expiry in the same cycle: completion wins.
- After the interval closes: bitmap and RAM contents hold until the next acqStart, so the readout streamer can scan them (it triggers on valid rise or active fall).
- Packets arriving after the interval closes are dropped.
- Index wrap: the full index range is valid; no out-of-range case.

Optional Feature:
- FMPS_DUPLICATE_COUNT_EN
  - Defined: 8-bit saturating counter of packets whose bitmap bit was already set during ST_ACTIVE; exposed on fmpsCSR[23:16]; saturates at 255; cleared on acqStart/reset.
  - Undefined: fmpsCSR[23:16] reads 0; no counter logic.

Decomposition:
- Shared package fmps_pkg:
  - CSR bit positions (CSR_ACTIVE_BIT=31, CSR_VALID_BIT=30, CSR_TIMEOUT_BIT=29, CSR_DUP_LSB=16)
  - state encodings
  - these bit positions are also used by the readout streamer.
- One natural sub-module: fmps_interval_timer (load/decrement/expire counter with zero-disables).

Test Plan:
- Mask=0x0000000F, timeout=0, packets idx 0..3 data 0xA0..0xA3 → four writes at N+1; valid rises 2 cycles after idx 3; CSR=0x40000004; bitmap=0xF.
- Mask=0xF, timeout=100, packets idx 0,1 only → at cycle 100 after start active falls, timedOut=1, valid=0; CSR=0x20000002.
- Mask=0x3, idx 0 twice (0x11 then 0x22), then idx 1 → RAM[0]=0x22; count=2; with FMPS_DUPLICATE_COUNT_EN CSR[23:16]=1, else 0.
- Packet idx 5 while idle → no write, bitmap 0; then acqStart and packet idx 5 in the same cycle → bitmap=0x20, count=1.
- acqStart mid-interval after 3 packets → bitmap cleared, count 0, active stays 1, valid never pulses for the aborted interval.
- sysReset asserted in ST_ACTIVE, then packets → all outputs 0, no writes until the next acqStart.
